// File: rtl/chimera_pkg.sv
// Shared Chimera types: wide AXI bundles, memory island window, router enums.
package chimera_pkg;

  localparam int unsigned WideIdW   = 4;
  localparam int unsigned WideAddrW = 48;
  localparam int unsigned WideDataW = 64;

  localparam logic [WideAddrW-1:0] MemislBase = 48'h0000_4800_0000;
  localparam logic [WideAddrW-1:0] MemislSize = 48'h0000_0010_0000;

  typedef enum logic [1:0] {
    MemislTgtIsl,
    MemislTgtByp,
    MemislTgtErr
  } memisl_tgt_e;

  typedef enum logic [1:0] {
    EwIdle,
    EwData,
    EwResp
  } memisl_ew_e;

  typedef enum logic {
    ErIdle,
    ErData
  } memisl_er_e;

  typedef struct packed {
    logic [WideIdW-1:0]   id;
    logic [WideAddrW-1:0] addr;
    logic [7:0]           len;
    logic [2:0]           size;
    logic [1:0]           burst;
  } chimera_wide_ax_t;

  typedef struct packed {
    logic [WideDataW-1:0]   data;
    logic [WideDataW/8-1:0] strb;
    logic                   last;
  } chimera_wide_w_t;

  typedef struct packed {
    logic [WideIdW-1:0] id;
    logic [1:0]         resp;
  } chimera_wide_b_t;

  typedef struct packed {
    logic [WideIdW-1:0]   id;
    logic [WideDataW-1:0] data;
    logic [1:0]           resp;
    logic                 last;
  } chimera_wide_r_t;

  typedef struct packed {
    chimera_wide_ax_t aw;
    logic             aw_valid;
    chimera_wide_w_t  w;
    logic             w_valid;
    logic             b_ready;
    chimera_wide_ax_t ar;
    logic             ar_valid;
    logic             r_ready;
  } chimera_wide_req_t;

  typedef struct packed {
    logic            aw_ready;
    logic            ar_ready;
    logic            w_ready;
    logic            b_valid;
    chimera_wide_b_t b;
    logic            r_valid;
    chimera_wide_r_t r;
  } chimera_wide_rsp_t;

endpackage

// File: rtl/chimera_memisland_wide_router_port.sv
// Single-port router: window decode, per-direction target lock, W-route
// FIFO and DECERR responders for out-of-window traffic.
module chimera_memisland_wide_router_port
  import chimera_pkg::*;
#(
  parameter int unsigned          AddrWidth = 48,
  parameter logic [AddrWidth-1:0] IslBase   = AddrWidth'(MemislBase),
  parameter logic [AddrWidth-1:0] IslSize   = AddrWidth'(MemislSize),
  parameter int unsigned          MaxTxns   = 8,
  parameter bit                   BypassEn  = 1'b1,
  parameter type axi_wide_req_t = chimera_wide_req_t,
  parameter type axi_wide_rsp_t = chimera_wide_rsp_t
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  axi_wide_req_t slv_req_i,
  output axi_wide_rsp_t slv_rsp_o,
  output axi_wide_req_t isl_req_o,
  input  axi_wide_rsp_t isl_rsp_i,
  output axi_wide_req_t byp_req_o,
  input  axi_wide_rsp_t byp_rsp_i
);

  localparam int unsigned CntW = $clog2(MaxTxns + 1);

  function automatic memisl_tgt_e f_decode(input logic [AddrWidth-1:0] a);
    logic [AddrWidth:0] w_a, w_lo, w_hi;
    w_a  = {1'b0, a};
    w_lo = {1'b0, IslBase};
    w_hi = w_lo + {1'b0, IslSize};
    if (w_a >= w_lo && w_a < w_hi) return MemislTgtIsl;
    return BypassEn ? MemislTgtByp : MemislTgtErr;
  endfunction

  axi_wide_rsp_t w_byp_rsp;
  memisl_tgt_e   w_aw_tgt, w_ar_tgt, w_wf_head;
  memisl_tgt_e   r_wtgt, r_rtgt;
  logic [CntW-1:0] r_wcnt, r_rcnt;
  logic [1:0]    w_wf_data;
  logic          w_wf_full, w_wf_empty;
  logic          w_aw_ok, w_ar_ok;
  logic          w_aw_rdy, w_ar_rdy, w_w_rdy;
  logic          w_b_vld, w_r_vld, w_r_last;
  logic          w_aw_hs, w_ar_hs, w_wl_hs, w_b_hs, w_r_hs, w_rl_hs;

  memisl_ew_e r_ew, w_ew_d;
  memisl_er_e r_er, w_er_d;
  logic [WideIdW-1:0] r_ew_id, r_er_id;
  logic [7:0]         r_er_len, r_er_beat;

  assign w_byp_rsp = BypassEn ? byp_rsp_i : '0;
  assign w_aw_tgt  = f_decode(slv_req_i.aw.addr);
  assign w_ar_tgt  = f_decode(slv_req_i.ar.addr);
  assign w_wf_head = memisl_tgt_e'(w_wf_data);

  assign w_aw_ok = ((r_wcnt == '0) || (w_aw_tgt == r_wtgt))
                && (r_wcnt < CntW'(MaxTxns)) && !w_wf_full
                && ((w_aw_tgt != MemislTgtErr) || (r_ew == EwIdle));
  assign w_ar_ok = ((r_rcnt == '0) || (w_ar_tgt == r_rtgt))
                && (r_rcnt < CntW'(MaxTxns))
                && ((w_ar_tgt != MemislTgtErr) || (r_er == ErIdle));

  always_comb begin
    w_aw_rdy = 1'b0;
    if (slv_req_i.aw_valid && w_aw_ok) begin
      case (w_aw_tgt)
        MemislTgtIsl: w_aw_rdy = isl_rsp_i.aw_ready;
        MemislTgtByp: w_aw_rdy = w_byp_rsp.aw_ready;
        default:      w_aw_rdy = 1'b1;
      endcase
    end
  end

  always_comb begin
    w_ar_rdy = 1'b0;
    if (slv_req_i.ar_valid && w_ar_ok) begin
      case (w_ar_tgt)
        MemislTgtIsl: w_ar_rdy = isl_rsp_i.ar_ready;
        MemislTgtByp: w_ar_rdy = w_byp_rsp.ar_ready;
        default:      w_ar_rdy = 1'b1;
      endcase
    end
  end

  always_comb begin
    w_w_rdy = 1'b0;
    if (slv_req_i.w_valid && !w_wf_empty) begin
      case (w_wf_head)
        MemislTgtIsl: w_w_rdy = isl_rsp_i.w_ready;
        MemislTgtByp: w_w_rdy = w_byp_rsp.w_ready;
        default:      w_w_rdy = (r_ew == EwData);
      endcase
    end
  end

  always_comb begin
    w_b_vld  = 1'b0;
    w_r_vld  = 1'b0;
    w_r_last = 1'b0;
    if (r_wcnt != '0) begin
      case (r_wtgt)
        MemislTgtIsl: w_b_vld = isl_rsp_i.b_valid;
        MemislTgtByp: w_b_vld = w_byp_rsp.b_valid;
        default:      w_b_vld = (r_ew == EwResp);
      endcase
    end
    if (r_rcnt != '0) begin
      case (r_rtgt)
        MemislTgtIsl: begin
          w_r_vld  = isl_rsp_i.r_valid;
          w_r_last = isl_rsp_i.r.last;
        end
        MemislTgtByp: begin
          w_r_vld  = w_byp_rsp.r_valid;
          w_r_last = w_byp_rsp.r.last;
        end
        default: begin
          w_r_vld  = (r_er == ErData);
          w_r_last = (r_er_beat == r_er_len);
        end
      endcase
    end
  end

  assign w_aw_hs = slv_req_i.aw_valid && w_aw_rdy;
  assign w_ar_hs = slv_req_i.ar_valid && w_ar_rdy;
  assign w_wl_hs = slv_req_i.w_valid && w_w_rdy && slv_req_i.w.last;
  assign w_b_hs  = w_b_vld && slv_req_i.b_ready;
  assign w_r_hs  = w_r_vld && slv_req_i.r_ready;
  assign w_rl_hs = w_r_hs && w_r_last;

  fifo_v3 #(
    .FALL_THROUGH (1'b1),
    .DATA_WIDTH   (2),
    .DEPTH        (MaxTxns)
  ) i_wfifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (1'b0),
    .full_o  (w_wf_full),
    .empty_o (w_wf_empty),
    .data_i  (w_aw_tgt),
    .push_i  (w_aw_hs),
    .data_o  (w_wf_data),
    .pop_i   (w_wl_hs)
  );

  always_comb begin
    isl_req_o          = slv_req_i;
    isl_req_o.aw_valid = 1'b0;
    isl_req_o.w_valid  = 1'b0;
    isl_req_o.b_ready  = 1'b0;
    isl_req_o.ar_valid = 1'b0;
    isl_req_o.r_ready  = 1'b0;
    byp_req_o          = isl_req_o;
    slv_rsp_o          = '0;
    slv_rsp_o.aw_ready = w_aw_rdy;
    slv_rsp_o.ar_ready = w_ar_rdy;
    slv_rsp_o.w_ready  = w_w_rdy;
    slv_rsp_o.b_valid  = w_b_vld;
    slv_rsp_o.r_valid  = w_r_vld;
    if (slv_req_i.aw_valid && w_aw_ok) begin
      isl_req_o.aw_valid = (w_aw_tgt == MemislTgtIsl);
      byp_req_o.aw_valid = (w_aw_tgt == MemislTgtByp);
    end
    if (slv_req_i.ar_valid && w_ar_ok) begin
      isl_req_o.ar_valid = (w_ar_tgt == MemislTgtIsl);
      byp_req_o.ar_valid = (w_ar_tgt == MemislTgtByp);
    end
    if (slv_req_i.w_valid && !w_wf_empty) begin
      isl_req_o.w_valid = (w_wf_head == MemislTgtIsl);
      byp_req_o.w_valid = (w_wf_head == MemislTgtByp);
    end
    if (r_wcnt != '0) begin
      case (r_wtgt)
        MemislTgtIsl: begin
          slv_rsp_o.b       = isl_rsp_i.b;
          isl_req_o.b_ready = slv_req_i.b_ready;
        end
        MemislTgtByp: begin
          slv_rsp_o.b       = w_byp_rsp.b;
          byp_req_o.b_ready = slv_req_i.b_ready;
        end
        default: begin
          slv_rsp_o.b.id   = r_ew_id;
          slv_rsp_o.b.resp = 2'b11;
        end
      endcase
    end
    if (r_rcnt != '0) begin
      case (r_rtgt)
        MemislTgtIsl: begin
          slv_rsp_o.r       = isl_rsp_i.r;
          isl_req_o.r_ready = slv_req_i.r_ready;
        end
        MemislTgtByp: begin
          slv_rsp_o.r       = w_byp_rsp.r;
          byp_req_o.r_ready = slv_req_i.r_ready;
        end
        default: begin
          slv_rsp_o.r.id   = r_er_id;
          slv_rsp_o.r.resp = 2'b11;
          slv_rsp_o.r.last = w_r_last;
        end
      endcase
    end
    if (!BypassEn) byp_req_o = '0;
  end

  always_comb begin
    w_ew_d = r_ew;
    case (r_ew)
      EwIdle: if (w_aw_hs && w_aw_tgt == MemislTgtErr) w_ew_d = EwData;
      EwData: if (w_wl_hs) w_ew_d = EwResp;
      EwResp: if (w_b_hs) w_ew_d = EwIdle;
      default: w_ew_d = EwIdle;
    endcase
  end

  always_comb begin
    w_er_d = r_er;
    case (r_er)
      ErIdle: if (w_ar_hs && w_ar_tgt == MemislTgtErr) w_er_d = ErData;
      ErData: if (w_rl_hs) w_er_d = ErIdle;
      default: w_er_d = ErIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ew <= EwIdle;
      r_er <= ErIdle;
    end else begin
      r_ew <= w_ew_d;
      r_er <= w_er_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ew_id   <= '0;
      r_er_id   <= '0;
      r_er_len  <= '0;
      r_er_beat <= '0;
    end else begin
      if (r_ew == EwIdle && w_aw_hs) r_ew_id <= slv_req_i.aw.id;
      if (r_er == ErIdle && w_ar_hs) begin
        r_er_id   <= slv_req_i.ar.id;
        r_er_len  <= slv_req_i.ar.len;
        r_er_beat <= '0;
      end else if (r_er == ErData && w_r_hs) begin
        r_er_beat <= r_er_beat + 8'd1;
      end
    end
  end

  // A simultaneous issue and retire leaves the count unchanged.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wcnt <= '0;
      r_rcnt <= '0;
      r_wtgt <= MemislTgtIsl;
      r_rtgt <= MemislTgtIsl;
    end else begin
      if (w_aw_hs) r_wtgt <= w_aw_tgt;
      if (w_ar_hs) r_rtgt <= w_ar_tgt;
      if (w_aw_hs && !w_b_hs)      r_wcnt <= r_wcnt + CntW'(1);
      else if (!w_aw_hs && w_b_hs) r_wcnt <= r_wcnt - CntW'(1);
      if (w_ar_hs && !w_rl_hs)      r_rcnt <= r_rcnt + CntW'(1);
      else if (!w_ar_hs && w_rl_hs) r_rcnt <= r_rcnt - CntW'(1);
    end
  end

endmodule

// File: rtl/fifo_v3.sv
// Small FIFO with the common_cells fifo_v3 interface subset.
// FALL_THROUGH makes a push visible on data_o in the same cycle.
module fifo_v3 #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  output logic                  full_o,
  output logic                  empty_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  push_i,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  pop_i
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_rd;
  logic [AW-1:0]         r_wr;
  logic [AW:0]           r_cnt;
  logic                  w_byp;
  logic                  w_wen;
  logic                  w_ren;
  logic                  w_emp;

  assign w_emp   = (r_cnt == '0);
  assign full_o  = (r_cnt == (AW+1)'(DEPTH));
  assign empty_o = w_emp && !(FALL_THROUGH && push_i);
  assign w_byp   = FALL_THROUGH && w_emp && push_i && pop_i;
  assign w_wen   = push_i && !full_o && !w_byp;
  assign w_ren   = pop_i && !w_emp;
  assign data_o  = (FALL_THROUGH && w_emp) ? data_i : r_mem[r_rd];

  always_ff @(posedge clk_i) begin
    if (w_wen) r_mem[r_wr] <= data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else if (flush_i) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_wen) r_wr <= (r_wr == AW'(DEPTH-1)) ? '0 : r_wr + AW'(1);
      if (w_ren) r_rd <= (r_rd == AW'(DEPTH-1)) ? '0 : r_rd + AW'(1);
      if (w_wen && !w_ren)      r_cnt <= r_cnt + (AW+1)'(1);
      else if (!w_wen && w_ren) r_cnt <= r_cnt - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/chimera_memisland_wide_router.sv
// Wide AXI router for the memory island: one independent
// router port per wide master.
module chimera_memisland_wide_router
  import chimera_pkg::*;
#(
  parameter int unsigned          NumWideMst = 1,
  parameter int unsigned          AddrWidth  = 48,
  parameter logic [AddrWidth-1:0] IslBase    = AddrWidth'(MemislBase),
  parameter logic [AddrWidth-1:0] IslSize    = AddrWidth'(MemislSize),
  parameter int unsigned          MaxTxns    = 8,
  parameter bit                   BypassEn   = 1'b1,
  parameter type axi_wide_req_t = chimera_wide_req_t,
  parameter type axi_wide_rsp_t = chimera_wide_rsp_t
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  axi_wide_req_t slv_req_i [NumWideMst],
  output axi_wide_rsp_t slv_rsp_o [NumWideMst],
  output axi_wide_req_t isl_req_o [NumWideMst],
  input  axi_wide_rsp_t isl_rsp_i [NumWideMst],
  output axi_wide_req_t byp_req_o [NumWideMst],
  input  axi_wide_rsp_t byp_rsp_i [NumWideMst]
);

  for (genvar i = 0; i < NumWideMst; i++) begin : g_port
    chimera_memisland_wide_router_port #(
      .AddrWidth      (AddrWidth),
      .IslBase        (IslBase),
      .IslSize        (IslSize),
      .MaxTxns        (MaxTxns),
      .BypassEn       (BypassEn),
      .axi_wide_req_t (axi_wide_req_t),
      .axi_wide_rsp_t (axi_wide_rsp_t)
    ) i_port (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .slv_req_i (slv_req_i[i]),
      .slv_rsp_o (slv_rsp_o[i]),
      .isl_req_o (isl_req_o[i]),
      .isl_rsp_i (isl_rsp_i[i]),
      .byp_req_o (byp_req_o[i]),
      .byp_rsp_i (byp_rsp_i[i])
    );
  end

endmodule

// File: tb/tb_chimera_memisland_wide_router.sv
// Directed bench: default router, DECERR variant and MaxTxns=2 variant.
module tb_chimera_memisland_wide_router;
  import chimera_pkg::*;

  localparam logic [47:0] Base = 48'h4800_0000;
  localparam logic [47:0] Size = 48'h0010_0000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  chimera_wide_req_t a_req [1], a_ireq [1], a_breq [1];
  chimera_wide_rsp_t a_rsp [1], a_irsp [1], a_brsp [1];
  chimera_wide_req_t b_req [1], b_ireq [1], b_breq [1];
  chimera_wide_rsp_t b_rsp [1], b_irsp [1], b_brsp [1];
  chimera_wide_req_t c_req [1], c_ireq [1], c_breq [1];
  chimera_wide_rsp_t c_rsp [1], c_irsp [1], c_brsp [1];

  chimera_memisland_wide_router ua (
    .clk_i(clk), .rst_ni(rst_n),
    .slv_req_i(a_req), .slv_rsp_o(a_rsp),
    .isl_req_o(a_ireq), .isl_rsp_i(a_irsp),
    .byp_req_o(a_breq), .byp_rsp_i(a_brsp)
  );

  chimera_memisland_wide_router #(.BypassEn(1'b0)) ub (
    .clk_i(clk), .rst_ni(rst_n),
    .slv_req_i(b_req), .slv_rsp_o(b_rsp),
    .isl_req_o(b_ireq), .isl_rsp_i(b_irsp),
    .byp_req_o(b_breq), .byp_rsp_i(b_brsp)
  );

  chimera_memisland_wide_router #(.MaxTxns(2)) uc (
    .clk_i(clk), .rst_ni(rst_n),
    .slv_req_i(c_req), .slv_rsp_o(c_rsp),
    .isl_req_o(c_ireq), .isl_rsp_i(c_irsp),
    .byp_req_o(c_breq), .byp_rsp_i(c_brsp)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic zero_all();
    a_req[0] = '0; a_irsp[0] = '0; a_brsp[0] = '0;
    b_req[0] = '0; b_irsp[0] = '0; b_brsp[0] = '0;
    c_req[0] = '0; c_irsp[0] = '0; c_brsp[0] = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    zero_all();
    tick(); tick();
    chk("rst_rsp_a", 64'(a_rsp[0] == '0), 1);
    chk("rst_isl_a", 64'(a_ireq[0] == '0), 1);
    chk("rst_byp_b", 64'(b_breq[0] == '0), 1);
    rst_n = 1'b1;
    tick();

    // In-window write burst, W beat 0 alongside AW
    a_irsp[0].aw_ready = 1; a_irsp[0].w_ready = 1;
    a_req[0].aw_valid = 1; a_req[0].aw.addr = Base + 48'h40;
    a_req[0].aw.id = 4'd1; a_req[0].aw.len = 8'd3;
    a_req[0].w_valid = 1; a_req[0].w.data = 64'h100;
    #1;
    chk("wr_isl_awv", 64'(a_ireq[0].aw_valid), 1);
    chk("wr_byp_awv", 64'(a_breq[0].aw_valid), 0);
    chk("wr_awrdy", 64'(a_rsp[0].aw_ready), 1);
    chk("wr_addr", 64'(a_ireq[0].aw.addr), 64'h4800_0040);
    chk("wr_w0_v", 64'(a_ireq[0].w_valid), 1);
    chk("wr_w0_rdy", 64'(a_rsp[0].w_ready), 1);
    tick();
    a_req[0].aw_valid = 0;
    for (int i = 1; i < 4; i++) begin
      a_req[0].w.data = 64'h100 + 64'(i);
      a_req[0].w.last = (i == 3);
      #1;
      chk("wr_wn_v", 64'(a_ireq[0].w_valid), 1);
      chk("wr_wn_data", a_ireq[0].w.data, 64'h100 + 64'(i));
      chk("wr_wn_last", 64'(a_ireq[0].w.last), 64'(i == 3));
      tick();
    end
    a_req[0].w_valid = 0; a_req[0].w.last = 0;
    a_irsp[0].b_valid = 1; a_irsp[0].b.id = 4'd1;
    a_irsp[0].b.resp = 2'b00; a_req[0].b_ready = 1;
    #1;
    chk("wr_bv", 64'(a_rsp[0].b_valid), 1);
    chk("wr_bid", 64'(a_rsp[0].b.id), 1);
    chk("wr_bresp", 64'(a_rsp[0].b.resp), 0);
    chk("wr_bready", 64'(a_ireq[0].b_ready), 1);
    tick();
    zero_all();

    // Window boundaries on the read side
    a_irsp[0].ar_ready = 0; a_brsp[0].ar_ready = 0;
    a_req[0].ar_valid = 1; a_req[0].ar.addr = Base + Size - 48'h1;
    #1;
    chk("rd_last_in", 64'(a_ireq[0].ar_valid), 1);
    a_req[0].ar.addr = Base - 48'h1;
    #1;
    chk("rd_below_byp", 64'(a_breq[0].ar_valid), 1);
    chk("rd_below_isl", 64'(a_ireq[0].ar_valid), 0);

    // First out-of-window byte goes to bypass
    a_brsp[0].ar_ready = 1;
    a_req[0].ar.addr = Base + Size; a_req[0].ar.len = 8'd1;
    a_req[0].ar.id = 4'd2; a_req[0].r_ready = 1;
    #1;
    chk("rd_byp_arv", 64'(a_breq[0].ar_valid), 1);
    chk("rd_isl_arv", 64'(a_ireq[0].ar_valid), 0);
    chk("rd_arrdy", 64'(a_rsp[0].ar_ready), 1);
    tick();
    a_req[0].ar_valid = 0;
    for (int i = 0; i < 2; i++) begin
      a_brsp[0].r_valid = 1; a_brsp[0].r.id = 4'd2;
      a_brsp[0].r.data = 64'hAA00 + 64'(i);
      a_brsp[0].r.last = (i == 1);
      #1;
      chk("rd_rv", 64'(a_rsp[0].r_valid), 1);
      chk("rd_rdata", a_rsp[0].r.data, 64'hAA00 + 64'(i));
      chk("rd_rlast", 64'(a_rsp[0].r.last), 64'(i == 1));
      chk("rd_byp_rrdy", 64'(a_breq[0].r_ready), 1);
      chk("rd_isl_rrdy", 64'(a_ireq[0].r_ready), 0);
      tick();
    end
    zero_all();

    // Three ISL writes outstanding, then a bypass AW
    a_irsp[0].aw_ready = 1; a_irsp[0].w_ready = 1;
    a_req[0].aw_valid = 1; a_req[0].aw.addr = Base;
    a_req[0].w_valid = 1; a_req[0].w.last = 1;
    tick(); tick(); tick();
    a_req[0].w_valid = 0; a_req[0].aw.addr = 48'h1000;
    a_brsp[0].aw_ready = 1; a_brsp[0].w_ready = 1;
    #1;
    chk("sw_stall_v", 64'(a_breq[0].aw_valid), 0);
    chk("sw_stall_r", 64'(a_rsp[0].aw_ready), 0);
    a_irsp[0].b_valid = 1; a_req[0].b_ready = 1;
    tick(); tick();
    #1;
    chk("sw_b3_stall", 64'(a_rsp[0].aw_ready), 0);
    chk("sw_b3_bv", 64'(a_rsp[0].b_valid), 1);
    tick();
    a_irsp[0].b_valid = 0;
    #1;
    chk("sw_go_v", 64'(a_breq[0].aw_valid), 1);
    chk("sw_go_r", 64'(a_rsp[0].aw_ready), 1);
    tick();
    a_req[0].aw_valid = 0; a_req[0].w_valid = 1;
    #1;
    chk("sw_w_byp", 64'(a_breq[0].w_valid), 1);
    chk("sw_w_isl", 64'(a_ireq[0].w_valid), 0);
    chk("sw_w_rdy", 64'(a_rsp[0].w_ready), 1);
    tick();
    a_req[0].w_valid = 0;
    a_brsp[0].b_valid = 1; a_brsp[0].b.id = 4'd7;
    #1;
    chk("sw_bv", 64'(a_rsp[0].b_valid), 1);
    chk("sw_bid", 64'(a_rsp[0].b.id), 7);
    tick();
    zero_all();

    // DECERR read, 8 beats
    b_req[0].ar_valid = 1; b_req[0].ar.addr = 48'h0;
    b_req[0].ar.len = 8'd7; b_req[0].ar.id = 4'd5;
    b_req[0].r_ready = 1; b_brsp[0].ar_ready = 1;
    #1;
    chk("er_arrdy", 64'(b_rsp[0].ar_ready), 1);
    chk("er_isl_arv", 64'(b_ireq[0].ar_valid), 0);
    chk("er_byp_tied", 64'(b_breq[0] == '0), 1);
    chk("er_rv_early", 64'(b_rsp[0].r_valid), 0);
    tick();
    b_req[0].ar_valid = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("er_rv", 64'(b_rsp[0].r_valid), 1);
      chk("er_rid", 64'(b_rsp[0].r.id), 5);
      chk("er_rresp", 64'(b_rsp[0].r.resp), 3);
      chk("er_rlast", 64'(b_rsp[0].r.last), 64'(i == 7));
      chk("er_rdata", b_rsp[0].r.data, 0);
      tick();
    end
    #1;
    chk("er_r_done", 64'(b_rsp[0].r_valid), 0);
    zero_all();

    // DECERR write interrupted by reset in WDATA
    b_req[0].aw_valid = 1; b_req[0].aw.id = 4'd3; b_req[0].aw.len = 8'd1;
    #1;
    chk("ew_awrdy", 64'(b_rsp[0].aw_ready), 1);
    tick();
    b_req[0].aw_valid = 0; b_req[0].w_valid = 1;
    #1;
    chk("ew_w0_rdy", 64'(b_rsp[0].w_ready), 1);
    tick();
    rst_n = 1'b0;
    zero_all();
    tick();
    chk("rst_mid_rsp", 64'(b_rsp[0] == '0), 1);
    chk("rst_mid_isl", 64'(b_ireq[0] == '0), 1);
    chk("rst_mid_byp", 64'(b_breq[0] == '0), 1);
    rst_n = 1'b1;
    tick();
    b_req[0].aw_valid = 1; b_req[0].aw.id = 4'd4; b_req[0].aw.len = 8'd0;
    b_req[0].w_valid = 1; b_req[0].w.last = 1;
    #1;
    chk("ew2_awrdy", 64'(b_rsp[0].aw_ready), 1);
    chk("ew2_w_wait", 64'(b_rsp[0].w_ready), 0);
    tick();
    b_req[0].aw_valid = 0;
    #1;
    chk("ew2_w_rdy", 64'(b_rsp[0].w_ready), 1);
    chk("ew2_b_early", 64'(b_rsp[0].b_valid), 0);
    tick();
    b_req[0].w_valid = 0; b_req[0].b_ready = 1;
    #1;
    chk("ew2_bv", 64'(b_rsp[0].b_valid), 1);
    chk("ew2_bid", 64'(b_rsp[0].b.id), 4);
    chk("ew2_bresp", 64'(b_rsp[0].b.resp), 3);
    tick();
    #1;
    chk("ew2_b_done", 64'(b_rsp[0].b_valid), 0);
    zero_all();

    // MaxTxns=2: third AR waits for an rlast
    c_irsp[0].ar_ready = 1;
    c_req[0].ar_valid = 1; c_req[0].ar.addr = Base; c_req[0].r_ready = 1;
    tick(); tick();
    #1;
    chk("mx_ar3_rdy", 64'(c_rsp[0].ar_ready), 0);
    chk("mx_ar3_v", 64'(c_ireq[0].ar_valid), 0);
    c_irsp[0].r_valid = 1; c_irsp[0].r.last = 1;
    #1;
    chk("mx_r_v", 64'(c_rsp[0].r_valid), 1);
    chk("mx_ar3_hold", 64'(c_rsp[0].ar_ready), 0);
    tick();
    c_irsp[0].r_valid = 0;
    #1;
    chk("mx_ar3_go", 64'(c_rsp[0].ar_ready), 1);
    chk("mx_ar3_isl", 64'(c_ireq[0].ar_valid), 1);
    tick();
    zero_all();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
